// File: rtl/matrix_mac_seq_pkg.sv
// Shared types and defaults for the sequential N x N matrix multiply-accumulate block.
package matrix_pkg;

    localparam int DEF_N = 3;
    localparam int DEF_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // Accumulator must hold a full dot product of N products of two W-bit values.
    function automatic int acc_width(input int n, input int w);
        return (2 * w) + $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_mac_seq_if.sv
// Operand/result bundle between a requester and the matrix multiplier.
interface matrix_mac_seq_if
    import matrix_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
);

    logic                 start;
    logic [N*N*W-1:0]     a_flat;
    logic [N*N*W-1:0]     b_flat;
    logic [N*N*W-1:0]     c_flat;
    logic                 busy;
    logic                 done;
    logic                 ovf;

    modport master (
        output start, a_flat, b_flat,
        input  c_flat, busy, done, ovf
    );

    modport slave (
        input  start, a_flat, b_flat,
        output c_flat, busy, done, ovf
    );

endinterface

// File: rtl/matrix_mac_seq_mac_unit.sv
// Single multiply-accumulate lane: sum_o is the accumulator plus the current product.
module mac_unit #(
    parameter int W  = 16,
    parameter int AW = 34
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [W-1:0]  a_in,
    input  logic [W-1:0]  b_in,
    output logic [AW-1:0] sum_o
);

    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_d;

    always_comb begin
        sum_o = acc_q + (AW'(a_in) * AW'(b_in));
    end

    // Clear wins over accumulate so a finished dot product never leaks into the next one.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum_o;
        end else begin
            acc_d = acc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matrix_mac_seq.sv
// Sequential C = A x B for unsigned N x N matrices, one multiply-accumulate per cycle.
module matrix_mac_seq
    import matrix_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic                  clk,
    input  logic                  rst,
    matrix_mac_seq_if.slave       bus
);

    localparam int             IW       = (N > 1) ? $clog2(N) : 1;
    localparam int             AW       = acc_width(N, W);
    localparam int             FW       = N * N * W;
    localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

    state_e          state_q, state_d;
    logic [FW-1:0]   a_q, a_d, b_q, b_d;
    logic [FW-1:0]   res_q, res_d, c_q, c_d;
    logic [IW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
    logic            pend_q, pend_d, ovf_q, ovf_d;

    logic            busy_s, done_s;
    logic            accept_s, compute_s, k_last_s, last_s, elem_ovf_s, mac_clr_s;
    logic [W-1:0]    a_el_s, b_el_s;
    logic [AW-1:0]   sum_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    state_d = bus.start ? ST_COMPUTE : ST_IDLE;
            ST_COMPUTE: state_d = last_s ? ST_DONE : ST_COMPUTE;
            ST_DONE:    state_d = bus.start ? ST_COMPUTE : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_q)
            ST_COMPUTE: begin
                busy_s = 1'b1;
                done_s = 1'b0;
            end
            ST_DONE: begin
                busy_s = 1'b0;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    always_comb begin
        compute_s  = (state_q == ST_COMPUTE);
        accept_s   = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        k_last_s   = (k_q == LAST_IDX);
        last_s     = compute_s && k_last_s && (j_q == LAST_IDX) && (i_q == LAST_IDX);
        mac_clr_s  = accept_s || (compute_s && k_last_s);
        a_el_s     = a_q[((int'(i_q) * N) + int'(k_q)) * W +: W];
        b_el_s     = b_q[((int'(k_q) * N) + int'(j_q)) * W +: W];
        elem_ovf_s = |sum_s[AW-1:W];
    end

    mac_unit #(
        .W  (W),
        .AW (AW)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .en    (compute_s),
        .clr   (mac_clr_s),
        .a_in  (a_el_s),
        .b_in  (b_el_s),
        .sum_o (sum_s)
    );

    // The final element is merged into res_d first so c_flat sees the complete matrix on the DONE edge.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        res_d  = res_q;
        c_d    = c_q;
        ovf_d  = ovf_q;
        pend_d = pend_q;
        i_d    = i_q;
        j_d    = j_q;
        k_d    = k_q;
        if (accept_s) begin
            a_d    = bus.a_flat;
            b_d    = bus.b_flat;
            pend_d = 1'b0;
            i_d    = '0;
            j_d    = '0;
            k_d    = '0;
        end else if (compute_s && k_last_s) begin
            res_d[((int'(i_q) * N) + int'(j_q)) * W +: W] = sum_s[W-1:0];
            pend_d = pend_q | elem_ovf_s;
            k_d    = '0;
            if (j_q == LAST_IDX) begin
                j_d = '0;
                i_d = (i_q == LAST_IDX) ? '0 : (i_q + IW'(1));
            end else begin
                j_d = j_q + IW'(1);
            end
            if (last_s) begin
                c_d   = res_d;
                ovf_d = pend_d;
            end else begin
                c_d   = c_q;
                ovf_d = ovf_q;
            end
        end else if (compute_s) begin
            k_d = k_q + IW'(1);
        end else begin
            k_d = k_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            pend_q <= 1'b0;
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            res_q  <= res_d;
            c_q    <= c_d;
            ovf_q  <= ovf_d;
            pend_q <= pend_d;
            i_q    <= i_d;
            j_q    <= j_d;
            k_q    <= k_d;
        end
    end

    assign bus.c_flat = c_q;
    assign bus.ovf    = ovf_q;
    assign bus.busy   = busy_s;
    assign bus.done   = done_s;

endmodule

// File: tb/tb_matrix_mac_seq.sv
// Directed self-checking bench for matrix_mac_seq with N=3, W=16.
module tb_matrix_mac_seq;

    localparam int N  = 3;
    localparam int W  = 16;
    localparam int FW = N * N * W;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   lat;
    int   pulses;

    int m_id  [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    int m_seq [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int m_rev [9] = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    int m_prod[9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

    logic [FW-1:0] all_ff;
    logic [FW-1:0] all_3;

    matrix_mac_seq_if #(.N(N), .W(W)) bus ();

    matrix_mac_seq #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] pk(input int v[9]);
        logic [FW-1:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) begin
            r[i*W +: W] = v[i][15:0];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Leaves the bench at the falling edge just before compute edge 1.
    task automatic launch(input logic [FW-1:0] a, input logic [FW-1:0] b);
        @(negedge clk);
        bus.a_flat = a;
        bus.b_flat = b;
        bus.start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    // c counts the edge about to sample the outputs; done should be seen by edge 28.
    task automatic run_to_done(input string tag, input logic [FW-1:0] hold, input int poke_at,
                               output int l);
        l = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 14) begin
                chk({tag, ".hold"}, bus.c_flat, hold);
                chk({tag, ".busy"}, FW'(bus.busy), FW'(1));
            end
            if (c == poke_at) begin
                bus.start  = 1'b1;
                bus.a_flat = all_ff;
            end else if (c == poke_at + 1) begin
                bus.start  = 1'b0;
            end
            if (bus.done === 1'b1) begin
                l = c;
                break;
            end
            @(negedge clk);
        end
        chk({tag, ".lat"}, FW'(l), FW'(28));
    endtask

    task automatic after_done(input string tag);
        @(negedge clk);
        chk({tag, ".done_drop"}, FW'(bus.done), FW'(0));
        chk({tag, ".idle"}, FW'(bus.busy), FW'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        clk        = 1'b0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.a_flat = '0;
        bus.b_flat = '0;
        all_ff     = {9{16'hFFFF}};
        all_3      = {9{16'h0003}};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.c", bus.c_flat, '0);
        chk("rst.ovf", FW'(bus.ovf), FW'(0));
        chk("rst.busy", FW'(bus.busy), FW'(0));
        chk("rst.done", FW'(bus.done), FW'(0));
        rst = 1'b0;

        launch(pk(m_id), pk(m_seq));
        chk("id.busy0", FW'(bus.busy), FW'(1));
        run_to_done("id", '0, 0, lat);
        chk("id.c", bus.c_flat, pk(m_seq));
        chk("id.ovf", FW'(bus.ovf), FW'(0));
        after_done("id");

        launch(all_ff, all_ff);
        run_to_done("ovf", pk(m_seq), 0, lat);
        chk("ovf.c", bus.c_flat, all_3);
        chk("ovf.ovf", FW'(bus.ovf), FW'(1));
        after_done("ovf");

        launch(all_ff, all_ff);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid.c", bus.c_flat, '0);
        chk("rstmid.ovf", FW'(bus.ovf), FW'(0));
        chk("rstmid.busy", FW'(bus.busy), FW'(0));
        chk("rstmid.done", FW'(bus.done), FW'(0));
        pulses = 0;
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        chk("rstmid.no_done", FW'(pulses), FW'(0));
        launch(pk(m_seq), pk(m_rev));
        run_to_done("rstmid.restart", '0, 0, lat);
        chk("rstmid.restart.c", bus.c_flat, pk(m_prod));
        chk("rstmid.restart.ovf", FW'(bus.ovf), FW'(0));
        after_done("rstmid.restart");

        launch(pk(m_seq), pk(m_id));
        run_to_done("ign", pk(m_prod), 5, lat);
        chk("ign.c", bus.c_flat, pk(m_seq));
        chk("ign.ovf", FW'(bus.ovf), FW'(0));
        pulses = 0;
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        chk("ign.single_done", FW'(pulses), FW'(0));

        launch(pk(m_id), pk(m_rev));
        run_to_done("b2b1", pk(m_seq), 0, lat);
        chk("b2b1.c", bus.c_flat, pk(m_rev));
        bus.a_flat = pk(m_seq);
        bus.b_flat = pk(m_rev);
        bus.start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start  = 1'b0;
        chk("b2b.rebusy", FW'(bus.busy), FW'(1));
        chk("b2b.c_keep", bus.c_flat, pk(m_rev));
        run_to_done("b2b2", pk(m_rev), 0, lat);
        chk("b2b2.c", bus.c_flat, pk(m_prod));
        chk("b2b2.ovf", FW'(bus.ovf), FW'(0));
        after_done("b2b2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_mac_seq.md
MATRIX_MAC_SEQ -- requirements
Module: matrix_mac_seq

Interface
REQ-001 SHALL have parameter N, default 3, meaning matrix dimension (N x N, N >= 2).
REQ-002 SHALL have parameter W, default 16, meaning unsigned element width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to multiply; sampled only while busy=0.
REQ-006 SHALL have port a_flat, input, N*N*W, matrix A; element (r,c) at bits [(r*N+c)*W +: W].
REQ-007 SHALL have port b_flat, input, N*N*W, matrix B; same packing as a_flat.
REQ-008 SHALL have port c_flat, output, N*N*W, result C = A x B; same packing.
REQ-009 SHALL have port busy, output, 1, high while computing.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port ovf, output, 1, high if any C element's true sum exceeded 2^W-1.

Function
REQ-012 SHALL implement FSM states IDLE, COMPUTE, DONE.
REQ-013 SHALL, on an edge with start=1 and busy=0 (state IDLE or DONE), capture a_flat/b_flat into internal registers, clear the accumulator, clear the pending overflow flag, set indices i=j=k=0 and enter COMPUTE.
REQ-014 SHALL, in COMPUTE, perform one multiply-accumulate acc += A[i][k]*B[k][j] per cycle, with acc wide enough to hold 2W+clog2(N) bits.
REQ-015 SHALL, when k=N-1, write the low W bits of the completed sum to internal result buffer element (i,j), OR the pending overflow flag with (sum > 2^W-1), clear acc, reset k, and advance j, then i (row-major).
REQ-016 SHALL leave COMPUTE for DONE after exactly N^3 compute cycles, on the edge that writes element (N-1,N-1).
REQ-017 SHALL, on the edge entering DONE, copy the result buffer to c_flat and the pending flag to ovf in the same edge.
REQ-018 SHALL hold done=1 only in DONE (one cycle); DONE then goes to IDLE, or to COMPUTE when start=1.
REQ-019 SHALL drive busy=1 only in COMPUTE.
REQ-020 SHALL assert done exactly N^3+1 edges after the edge that accepted start (28 for N=3).
REQ-021 SHALL ignore start while busy=1; input changes during COMPUTE SHALL NOT affect the result.
REQ-022 SHALL hold c_flat and ovf stable between done pulses; they SHALL NOT change during COMPUTE.
REQ-023 SHALL treat all arithmetic as unsigned, with results wrapping modulo 2^W.

Reset
REQ-024 SHALL, when rst=1 at an edge, enter IDLE and set c_flat=0, ovf=0, busy=0, done=0, and clear acc and the indices; rst takes priority over start.
REQ-025 SHALL abort an in-flight operation on reset mid-COMPUTE, with no done pulse issued.

Structure
REQ-026 SHALL place the state enum and the default N/W constants in shared package matrix_pkg.
REQ-027 SHALL instantiate one sub-module mac_unit (W x W multiply, wide accumulate, clear input) for the datapath.

Verification
REQ-028 SHALL cover identity: N=3, W=16, A=I, B=[1..9] row-major -> c_flat=[1..9], ovf=0, done 28 edges after start.
REQ-029 SHALL cover overflow: all A and B elements 0xFFFF -> every C element 0x0003 (0x2FFFA0003 mod 2^16), ovf=1.
REQ-030 SHALL cover start ignored: start pulsed at compute cycle 5 with different A -> a single done at edge 28 with the original result.
REQ-031 SHALL cover reset mid-operation: rst at compute cycle 10 -> no done, all outputs 0; a new start completes normally 28 edges later.
REQ-032 SHALL cover back-to-back: start held high in the DONE cycle with new operands -> second done exactly 28 edges later with the new result, and c_flat unchanged in between.
